// File: rtl/mc_datapath_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_datapath_pkg                                                      |
// | Shared select encodings, NOP constant and handshake state codes.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mc_datapath_pkg;

    typedef enum logic [1:0] {
        SRC_A_ZERO   = 2'b00,
        SRC_A_REG    = 2'b01,
        SRC_A_OLD_PC = 2'b10,
        SRC_A_PC     = 2'b11
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRC_B_REG  = 2'b00,
        SRC_B_WORD = 2'b01,
        SRC_B_IMM  = 2'b10,
        SRC_B_ZERO = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        RES_ALU_OUT = 2'b00,
        RES_DATA    = 2'b01,
        RES_ALU_RES = 2'b10,
        RES_OLD_PC  = 2'b11
    } result_src_e;

    // addi x0, x0, 0
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_ERR  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mc_datapath_mem_handshake.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_handshake                                                        |
// | Memory request FSM (IDLE/REQ/ERR) with request latch and timeout.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_handshake
    import mc_datapath_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_start,
    input  logic            mem_we,
    input  logic            fetch,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            mem_ready,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_wr,
    output logic            busy,
    output logic            mem_err,
    output logic            load_done,
    output logic            fetch_done
);

    localparam int unsigned    CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  c_TIMEOUT = CW'(TIMEOUT);

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_inc;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic            r_wr;
    logic            r_fetch;

    assign w_count_inc = r_count + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A ready arriving on the final allowed cycle wins over the timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (mem_start) w_state_next = c_ST_REQ;
            c_ST_REQ: begin
                if (mem_ready) begin
                    w_state_next = c_ST_IDLE;
                end else if (w_count_inc == c_TIMEOUT) begin
                    w_state_next = c_ST_ERR;
                end
            end
            c_ST_ERR:  w_state_next = c_ST_ERR;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        mem_valid  = (r_state == c_ST_REQ);
        busy       = (r_state == c_ST_REQ) || ((r_state == c_ST_IDLE) && mem_start);
        mem_err    = (r_state == c_ST_ERR);
        load_done  = (r_state == c_ST_REQ) && mem_ready && !r_wr;
        fetch_done = load_done && r_fetch;
        mem_addr   = (r_state == c_ST_REQ) ? r_addr : addr;
        mem_wdata  = r_wdata;
        mem_wr     = (r_state == c_ST_REQ) && r_wr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            r_fetch <= 1'b0;
            r_count <= '0;
        end else if ((r_state == c_ST_IDLE) && mem_start) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_wr    <= mem_we;
            r_fetch <= fetch;
            r_count <= '0;
        end else if ((r_state == c_ST_REQ) && !mem_ready && (r_count != c_TIMEOUT)) begin
            r_count <= w_count_inc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_datapath                                                          |
// | Multicycle datapath registers, operand/result muxes and memory port. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mc_datapath
    import mc_datapath_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      alu_src_a,
    input  logic [1:0]      alu_src_b,
    input  logic [1:0]      result_src,
    input  logic            adr_src,
    input  logic            ir_write,
    input  logic            pc_write,
    input  logic            mem_start,
    input  logic            mem_we,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_res,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [XLEN-1:0] result,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] old_pc,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_wr,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy,
    output logic            mem_err
);

    localparam logic [XLEN-1:0] c_WORD_BYTES = XLEN'(XLEN / 8);

    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_alu_out;
    logic [XLEN-1:0] r_data;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_old_pc;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] w_addr;
    logic            w_busy;
    logic            w_load_done;
    logic            w_fetch_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_alu_out <= '0;
        end else begin
            r_a       <= rs1_data;
            r_b       <= rs2_data;
            r_alu_out <= alu_res;
        end
    end

    // The PC is frozen for the whole access so old_pc records the fetch address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_old_pc <= RESET_PC;
            r_instr  <= c_NOP;
            r_data   <= '0;
        end else begin
            if (pc_write && !w_busy) r_pc <= result;
            if (w_load_done) r_data <= mem_rdata;
            if (w_fetch_done) begin
                r_instr  <= mem_rdata[31:0];
                r_old_pc <= r_pc;
            end
        end
    end

    always_comb begin
        alu_a = '0;
        case (alu_src_a_e'(alu_src_a))
            SRC_A_ZERO:   alu_a = '0;
            SRC_A_REG:    alu_a = r_a;
            SRC_A_OLD_PC: alu_a = r_old_pc;
            SRC_A_PC:     alu_a = r_pc;
            default:      alu_a = '0;
        endcase

        alu_b = '0;
        case (alu_src_b_e'(alu_src_b))
            SRC_B_REG:  alu_b = r_b;
            SRC_B_WORD: alu_b = c_WORD_BYTES;
            SRC_B_IMM:  alu_b = imm_ext;
            SRC_B_ZERO: alu_b = '0;
            default:    alu_b = '0;
        endcase

        result = '0;
        case (result_src_e'(result_src))
            RES_ALU_OUT: result = r_alu_out;
            RES_DATA:    result = r_data;
            RES_ALU_RES: result = alu_res;
            RES_OLD_PC:  result = r_old_pc;
            default:     result = '0;
        endcase

        w_addr = adr_src ? result : r_pc;
    end

    assign pc     = r_pc;
    assign old_pc = r_old_pc;
    assign instr  = r_instr;
    assign busy   = w_busy;

    mem_handshake #(
        .XLEN    (XLEN),
        .TIMEOUT (TIMEOUT)
    ) u_mem_handshake (
        .clk        (clk),
        .reset      (reset),
        .mem_start  (mem_start),
        .mem_we     (mem_we),
        .fetch      (ir_write),
        .addr       (w_addr),
        .wdata      (r_b),
        .mem_ready  (mem_ready),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr     (mem_wr),
        .busy       (w_busy),
        .mem_err    (mem_err),
        .load_done  (w_load_done),
        .fetch_done (w_fetch_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mc_datapath                                                       |
// | Vector table, directed memory sequences and randomized model check.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mc_datapath;

    localparam int          TO  = 16;
    localparam logic [31:0] RPC = 32'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic        adr_src, ir_write, pc_write, mem_start, mem_we, mem_ready;
    logic [31:0] rs1_data, rs2_data, imm_ext, alu_res, mem_rdata;
    logic [31:0] alu_a, alu_b, result, instr, pc, old_pc, mem_addr, mem_wdata;
    logic        mem_valid, mem_wr, busy, mem_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_datapath #(.XLEN(32), .RESET_PC(RPC), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .mem_start(mem_start), .mem_we(mem_we),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_ext(imm_ext), .alu_res(alu_res),
        .alu_a(alu_a), .alu_b(alu_b), .result(result), .instr(instr),
        .pc(pc), .old_pc(old_pc),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .mem_err(mem_err)
    );

    typedef struct {
        logic [1:0]  sa, sb, rs;
        logic [31:0] r1, r2, imm, ar;
        logic [31:0] ea, eb, er;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_src_a = 2'b00; alu_src_b = 2'b00; result_src = 2'b00;
        adr_src = 1'b0; ir_write = 1'b0; pc_write = 1'b0;
        mem_start = 1'b0; mem_we = 1'b0; mem_ready = 1'b0;
        rs1_data = '0; rs2_data = '0; imm_ext = '0; alu_res = '0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Caller has mem_start and friends set; ready is offered on REQ cycle ready_at (0 = never).
    task automatic run_access(input int ready_at, output int cnt);
        cnt = 0;
        tick();
        mem_start = 1'b0; ir_write = 1'b0; mem_we = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            mem_ready = (i == ready_at);
            if (mem_valid) cnt++;
            tick();
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [31:0] m_a, m_b, m_ao, m_data, m_pc, m_opc, m_instr, m_addr, m_wd;
        logic [31:0] va[4], vb[4], vr[4];
        logic [31:0] e_res, e_addr;
        bit m_pend, m_wr, m_fetch, e_busy;
        int m_left;

        vt[0] = '{2'b01, 2'b00, 2'b00, 32'd5, 32'd7, 32'h0, 32'hAA, 32'd5, 32'd7, 32'hAA};
        vt[1] = '{2'b00, 2'b01, 2'b10, 32'd1, 32'd2, 32'h0, 32'h33, 32'd0, 32'd4, 32'h33};
        vt[2] = '{2'b10, 2'b10, 2'b11, 32'd3, 32'd4, 32'h1234, 32'h55, 32'h100, 32'h1234, 32'h100};
        vt[3] = '{2'b11, 2'b11, 2'b01, 32'd9, 32'd9, 32'h0, 32'h66, 32'h100, 32'd0, 32'd0};
        vt[4] = '{2'b01, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h1234_5678,
                  32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};

        do_reset();
        chk("rst_pc", pc, RPC);
        chk("rst_old_pc", old_pc, RPC);
        chk("rst_instr", instr, 32'h13);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_err", mem_err, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_out", result, 0);

        for (int i = 0; i < 5; i++) begin
            rs1_data = vt[i].r1; rs2_data = vt[i].r2; imm_ext = vt[i].imm; alu_res = vt[i].ar;
            alu_src_a = vt[i].sa; alu_src_b = vt[i].sb; result_src = vt[i].rs;
            tick();
            chk($sformatf("vec%0d_alu_a", i), alu_a, vt[i].ea);
            chk($sformatf("vec%0d_alu_b", i), alu_b, vt[i].eb);
            chk($sformatf("vec%0d_result", i), result, vt[i].er);
        end

        // instruction fetch, ready on the third request cycle
        idle_inputs();
        mem_start = 1'b1; ir_write = 1'b1; mem_rdata = 32'h0050_0093;
        #1;
        chk("fetch_busy_same_cycle", busy, 1);
        chk("fetch_addr", mem_addr, RPC);
        run_access(3, cnt);
        chk("fetch_valid_cycles", cnt, 3);
        chk("fetch_instr", instr, 32'h0050_0093);
        chk("fetch_old_pc", old_pc, RPC);
        result_src = 2'b01;
        #1;
        chk("fetch_data_reg", result, 32'h0050_0093);

        // store: address and data must hold while alu_res/rs2 move
        idle_inputs();
        rs2_data = 32'hDEAD_BEEF;
        tick();
        result_src = 2'b10; alu_res = 32'h40; adr_src = 1'b1; mem_we = 1'b1; mem_start = 1'b1;
        #1;
        chk("store_addr_comb", mem_addr, 32'h40);
        tick();
        mem_start = 1'b0; mem_we = 1'b0; alu_res = 32'h77; rs2_data = '0; adr_src = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            chk($sformatf("store_valid_c%0d", i), mem_valid, 1);
            chk($sformatf("store_addr_c%0d", i), mem_addr, 32'h40);
            chk($sformatf("store_wdata_c%0d", i), mem_wdata, 32'hDEAD_BEEF);
            chk($sformatf("store_wr_c%0d", i), mem_wr, 1);
            mem_ready = (i == 2); mem_rdata = 32'hBAD0_BAD0;
            tick();
        end
        mem_ready = 1'b0;
        chk("store_done_valid", mem_valid, 0);
        result_src = 2'b01;
        #1;
        chk("store_no_data_load", result, 32'h0050_0093);

        // pc_write while busy is dropped, then taken when idle
        idle_inputs();
        mem_start = 1'b1; pc_write = 1'b1; result_src = 2'b10; alu_res = 32'h999;
        tick();
        mem_start = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; pc_write = 1'b0;
        chk("pc_hold_busy", pc, RPC);
        alu_src_a = 2'b11; alu_src_b = 2'b01; result_src = 2'b10; alu_res = RPC + 32'd4;
        #1;
        chk("pc_alu_a", alu_a, RPC);
        chk("pc_alu_b", alu_b, 32'd4);
        pc_write = 1'b1;
        tick();
        pc_write = 1'b0;
        chk("pc_write_idle", pc, 32'h104);

        // ready on exactly the last allowed cycle
        idle_inputs();
        mem_start = 1'b1; mem_rdata = 32'hCAFE_0016;
        run_access(TO, cnt);
        chk("edge16_valid_cycles", cnt, TO);
        chk("edge16_mem_err", mem_err, 0);
        result_src = 2'b01;
        #1;
        chk("edge16_data", result, 32'hCAFE_0016);

        // asynchronous reset in the middle of a request
        idle_inputs();
        mem_start = 1'b1;
        tick();
        mem_start = 1'b0;
        chk("midrst_valid_before", mem_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid_drop", mem_valid, 0);
        chk("midrst_busy", busy, 0);
        tick();
        reset = 1'b0;
        chk("midrst_pc", pc, RPC);

        // randomized run against the transaction model
        m_a = '0; m_b = '0; m_ao = '0; m_data = '0; m_pc = RPC; m_opc = RPC; m_instr = 32'h13;
        m_addr = '0; m_wd = '0; m_pend = 0; m_wr = 0; m_fetch = 0; m_left = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rs1_data = $urandom; rs2_data = $urandom; imm_ext = $urandom; alu_res = $urandom;
            mem_rdata = $urandom;
            alu_src_a = 2'($urandom_range(0, 3));
            alu_src_b = 2'($urandom_range(0, 3));
            result_src = 2'($urandom_range(0, 3));
            adr_src = 1'($urandom_range(0, 1));
            pc_write = ($urandom_range(0, 3) == 0);
            mem_start = ($urandom_range(0, 4) == 0);
            mem_we = 1'($urandom_range(0, 1));
            ir_write = 1'($urandom_range(0, 1));
            mem_ready = m_pend ? (m_left == 1) : 1'($urandom_range(0, 1));

            va = '{32'd0, m_a, m_opc, m_pc};
            vb = '{m_b, 32'd4, imm_ext, 32'd0};
            vr = '{m_ao, m_data, alu_res, m_opc};
            e_res  = vr[result_src];
            e_busy = m_pend || mem_start;
            e_addr = m_pend ? m_addr : (adr_src ? e_res : m_pc);
            #1;
            chk("rnd_alu_a", alu_a, va[alu_src_a]);
            chk("rnd_alu_b", alu_b, vb[alu_src_b]);
            chk("rnd_result", result, e_res);
            chk("rnd_busy", busy, e_busy);
            chk("rnd_valid", mem_valid, m_pend);
            chk("rnd_addr", mem_addr, e_addr);
            chk("rnd_pc", pc, m_pc);
            chk("rnd_old_pc", old_pc, m_opc);
            chk("rnd_instr", instr, m_instr);
            chk("rnd_mem_err", mem_err, 0);
            if (m_pend) begin
                chk("rnd_wdata", mem_wdata, m_wd);
                chk("rnd_wr", mem_wr, m_wr);
            end
            @(posedge clk);
            if (m_pend) begin
                if (m_left == 1) begin
                    m_pend = 0;
                    if (!m_wr) begin
                        m_data = mem_rdata;
                        if (m_fetch) begin
                            m_instr = mem_rdata;
                            m_opc = m_pc;
                        end
                    end
                end else begin
                    m_left--;
                end
            end else if (mem_start) begin
                m_pend = 1; m_left = $urandom_range(1, TO);
                m_addr = e_addr; m_wd = m_b; m_wr = mem_we; m_fetch = ir_write;
            end
            if (pc_write && !e_busy) m_pc = e_res;
            m_a = rs1_data; m_b = rs2_data; m_ao = alu_res;
            #1;
        end
        // drain any access still open
        idle_inputs();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();

        // timeout: no ready at all
        idle_inputs();
        mem_start = 1'b1;
        run_access(0, cnt);
        chk("to_valid_cycles", cnt, TO);
        chk("to_mem_err", mem_err, 1);
        chk("to_valid_low", mem_valid, 0);
        mem_start = 1'b1;
        #1;
        chk("to_err_busy", busy, 0);
        tick();
        mem_start = 1'b0;
        chk("to_err_start_ignored", mem_valid, 0);
        chk("to_err_sticky", mem_err, 1);
        do_reset();
        chk("to_reset_clears", mem_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width (32 or 64); RESET_PC, default 0, PC value after reset; TIMEOUT, default 16, max cycles waiting for mem_ready.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- alu_src_a  in  2  ALU A select: 00 zero, 01 A reg, 10 old_pc, 11 pc
- alu_src_b  in  2  ALU B select: 00 B reg, 01 constant XLEN/8, 10 imm_ext, 11 zero
- result_src  in  2  result select: 00 alu_out reg, 01 data reg, 10 alu_res, 11 old_pc
- adr_src  in  1  memory address select: 0 pc, 1 result
- ir_write  in  1  load instr and old_pc from fetched word
- pc_write  in  1  load pc from result
- mem_start  in  1  one-cycle request to start a memory access
- mem_we  in  1  access is a store, sampled with mem_start
- rs1_data, rs2_data  in  XLEN  register file read data
- imm_ext  in  XLEN  extended immediate
- alu_res  in  XLEN  combinational ALU result
- alu_a, alu_b  out  XLEN  ALU operands
- result  out  XLEN  result bus
- instr  out  32  instruction register
- pc, old_pc  out  XLEN  program counters
- mem_valid  out  1  request valid
- mem_addr  out  XLEN  request address
- mem_wdata  out  XLEN  store data
- mem_wr  out  1  request is a store
- mem_ready  in  1  memory accepts/completes request
- mem_rdata  in  XLEN  load data, valid with mem_ready
- busy  out  1  access in progress; controller SHALL stall
- mem_err  out  1  sticky timeout flag

Function
REQ-003 A and B regs SHALL capture rs1_data/rs2_data every cycle; alu_out reg SHALL capture alu_res every cycle (one-cycle latency).
REQ-004 alu_a, alu_b, result, mem_addr SHALL be combinational from the selects and registers.
REQ-005 Memory handshake FSM SHALL have states IDLE, REQ, ERR.
REQ-006 IDLE: on mem_start, latch mem_addr, mem_wdata (=B reg), mem_wr, enter REQ next cycle; busy SHALL assert that same cycle (combinational from mem_start).
REQ-007 REQ: mem_valid=1, busy=1, address/data/wr held stable; on mem_ready, return to IDLE, and for loads capture mem_rdata into data reg and, if ir_write was asserted at start, into instr (low 32 bits) with old_pc<=pc.
REQ-008 REQ: a timeout counter SHALL count cycles without mem_ready; at TIMEOUT cycles, go to ERR, drop mem_valid, set mem_err.
REQ-009 ERR: busy=0, mem_valid=0; mem_start ignored; only reset leaves ERR.
REQ-010 mem_ready in the same cycle the counter hits TIMEOUT SHALL count as success (IDLE, no error).
REQ-011 mem_start while busy SHALL be ignored; mem_ready in IDLE SHALL be ignored.
REQ-012 pc SHALL update on pc_write only when not busy; pc_write during busy SHALL be dropped.
REQ-013 Counter SHALL be $clog2(TIMEOUT+1) bits, cleared on entering REQ, never wraps.
REQ-014 Constant B (XLEN/8) SHALL be zero-extended to XLEN.

Reset
REQ-015 On reset (asynchronous): pc=RESET_PC, old_pc=RESET_PC, instr=32'h00000013 (NOP), A/B/alu_out/data regs=0, FSM=IDLE, counter=0, mem_valid=0, mem_wr=0, mem_err=0.
REQ-016 Reset mid-REQ SHALL drop mem_valid immediately and discard the access.

Structure
REQ-017 Select encodings (alu_src_a/b, result_src) and NOP constant SHALL be typedefs/constants in the shared types package.
REQ-018 Handshake FSM and timeout counter SHALL be sub-module mem_handshake; register/mux logic stays in mc_datapath.

Verification
REQ-019 Reset with RESET_PC=0x100 -> pc=0x100, instr=0x00000013, mem_valid=0, mem_err=0.
REQ-020 Fetch: mem_start, ir_write, adr_src=0, mem_ready after 3 cycles with rdata=0x00500093 -> instr=0x00500093, old_pc=0x100, mem_valid high exactly 3 cycles.
REQ-021 Store: B=0xDEADBEEF, result=0x40, adr_src=1, mem_we -> mem_addr=0x40, mem_wdata=0xDEADBEEF, mem_wr=1 held until mem_ready.
REQ-022 Timeout: no mem_ready for 16 cycles -> mem_err=1, mem_valid=0, later mem_start ignored until reset.
REQ-023 mem_ready on cycle 16 exactly -> load completes, mem_err=0.
REQ-024 pc_write during busy -> pc unchanged; pc_write when idle with alu_src_a=11, alu_src_b=01, result_src=10 (alu_res=pc+4) -> pc=0x104.
